// File: rtl/pe_psum_collector_if.sv
// pe_psum_collector_if: bundles the PE-side input stream, the group-size
//   control and the FIFO output handshake of pe_psum_collector.
// Ports: en/num_rows (control), opsum_seln/opsum_in (PE stream),
//   out_valid/out_ready/out_data (FIFO head), fifo_count/drop_err (status).
// master = block driving the collector, slave = the collector itself.
interface pe_psum_collector_if #(
  parameter int DATA_W     = 16,
  parameter int ACC_W      = 24,
  parameter int FIFO_DEPTH = 4
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic              en;
  logic [7:0]        num_rows;
  logic              opsum_seln;
  logic [DATA_W-1:0] opsum_in;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_data;
  logic [CNT_W-1:0]  fifo_count;
  logic              drop_err;

  modport master (
    output en,
    output num_rows,
    output opsum_seln,
    output opsum_in,
    output out_ready,
    input  out_valid,
    input  out_data,
    input  fifo_count,
    input  drop_err
  );

  modport slave (
    input  en,
    input  num_rows,
    input  opsum_seln,
    input  opsum_in,
    input  out_ready,
    output out_valid,
    output out_data,
    output fifo_count,
    output drop_err
  );
endinterface

// File: rtl/pe_psum_collector.sv
// pe_psum_collector: accumulates groups of num_rows signed PE partial sums and
//   queues each group total in a small first-word-fall-through FIFO.
// Latency: group total appears at the FIFO head two cycles after the cycle that
//   carries the last opsum of the group (one PUSH cycle in between).
// Backpressure: a full FIFO holds the FSM in PUSH; opsums arriving while held
//   are discarded and raise the sticky drop_err flag.
// Ports: clk, rst (sync, active-high), io (pe_psum_collector_if.slave).
// Build option: define PE_PSUM_SATURATE_EN to saturate every addition at the
//   signed ACC_W limits; left undefined, the accumulator wraps modulo 2^ACC_W.

// pe_psum_fifo: first-word-fall-through FIFO, head visible while count != 0.
//   Zero cycles from storage to head; one cycle from push to head.
//   Caller only pushes when not full or when popping in the same cycle.
module pe_psum_fifo #(
  parameter int W     = 24,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [W-1:0]           push_dat,
  input  logic                   pop,
  output logic                   head_vld,
  output logic [W-1:0]           head_dat,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_pop;

  assign head_vld = (count_q != '0);
  assign full     = (count_q == CNT_W'(DEPTH));
  // Popping an empty FIFO is silently ignored.
  assign do_pop   = pop & head_vld;
  // Head reads as zero when empty so the output is clean after reset even
  // though the storage array itself is not reset.
  assign head_dat = head_vld ? mem_q[rd_ptr_q] : '0;
  assign count    = count_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      // When full, wr_ptr equals rd_ptr: this overwrites the head that is
      // being popped on the same edge, which is exactly what we want.
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end
endmodule

module pe_psum_collector #(
  parameter int DATA_W     = 16,
  parameter int ACC_W      = 24,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  pe_psum_collector_if.slave  io
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_PUSH  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [7:0]       row_cnt_q, row_cnt_d;
  logic [7:0]       rows_q, rows_d;
  logic             drop_err_q, drop_err_d;

  logic             opsum_vld;
  logic [ACC_W-1:0] opsum_ext;
  logic [ACC_W-1:0] sum;

  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_head_vld;
  logic [ACC_W-1:0] fifo_head_dat;
  logic [CNT_W-1:0] fifo_cnt;
  logic             push_ok;

  assign opsum_vld = ~io.opsum_seln;
  assign opsum_ext = {{(ACC_W - DATA_W){io.opsum_in[DATA_W-1]}}, io.opsum_in};

`ifdef PE_PSUM_SATURATE_EN
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic [ACC_W-1:0] sum_raw;
  logic             sum_ovf;

  // Signed overflow only happens when both operands share a sign and the
  // result sign differs; clamp toward the operands' sign in that case.
  always_comb begin
    sum_raw = acc_q + opsum_ext;
    sum_ovf = (acc_q[ACC_W-1] == opsum_ext[ACC_W-1]) &&
              (sum_raw[ACC_W-1] != acc_q[ACC_W-1]);
    if (sum_ovf) begin
      sum = acc_q[ACC_W-1] ? ACC_MIN : ACC_MAX;
    end else begin
      sum = sum_raw;
    end
  end
`else
  assign sum = acc_q + opsum_ext;
`endif

  // A full FIFO still accepts a push when its head leaves on the same edge.
  assign fifo_pop  = fifo_head_vld & io.out_ready;
  assign push_ok   = ~fifo_full | fifo_pop;
  assign fifo_push = (state_q == S_PUSH) & push_ok;

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    row_cnt_d  = row_cnt_q;
    rows_d     = rows_q;
    drop_err_d = drop_err_q;

    case (state_q)
      S_IDLE: begin
        // Opsums seen here belong to no group and are ignored silently.
        acc_d     = '0;
        row_cnt_d = '0;
        if (io.en) begin
          rows_d  = (io.num_rows == 8'd0) ? 8'd1 : io.num_rows;
          state_d = S_ACCUM;
        end
      end

      S_ACCUM: begin
        // en is not consulted: a started group always runs to completion.
        if (opsum_vld) begin
          acc_d = sum;
          if (row_cnt_q == rows_q - 8'd1) begin
            state_d = S_PUSH;
          end else begin
            row_cnt_d = row_cnt_q + 8'd1;
          end
        end
      end

      S_PUSH: begin
        if (push_ok) begin
          acc_d     = '0;
          row_cnt_d = '0;
          state_d   = io.en ? S_ACCUM : S_IDLE;
        end else if (opsum_vld) begin
          // Stalled on a full FIFO: there is nowhere to put this opsum.
          drop_err_d = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      acc_q      <= '0;
      row_cnt_q  <= '0;
      rows_q     <= 8'd1;
      drop_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      row_cnt_q  <= row_cnt_d;
      rows_q     <= rows_d;
      drop_err_q <= drop_err_d;
    end
  end

  pe_psum_fifo #(
    .W     (ACC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fifo_push),
    .push_dat (acc_q),
    .pop      (fifo_pop),
    .head_vld (fifo_head_vld),
    .head_dat (fifo_head_dat),
    .count    (fifo_cnt),
    .full     (fifo_full)
  );

  assign io.out_valid  = fifo_head_vld;
  assign io.out_data   = fifo_head_dat;
  assign io.fifo_count = fifo_cnt;
  assign io.drop_err   = drop_err_q;
endmodule

// File: tb/tb_pe_psum_collector.sv
// tb_pe_psum_collector: table-driven group sums plus hand-written sequences
//   for latency, num_rows=0, full FIFO / drop, same-cycle push+pop, reset,
//   and accumulator width limits (second instance with ACC_W=18).
module tb_pe_psum_collector;
  localparam int DATA_W  = 16;
  localparam int ACC_W   = 24;
  localparam int ACC_W_N = 18;
  localparam int DEPTH   = 4;
  localparam int NV      = 8;
  localparam int DRAIN_BOUND = 60;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              en = 1'b0;
  logic [7:0]        num_rows = 8'd0;
  logic              opsum_seln = 1'b1;
  logic [DATA_W-1:0] opsum_in = '0;
  logic              out_ready = 1'b0;

  int checks = 0;
  int failures = 0;
  logic signed [ACC_W-1:0] exp_q[$];

  always #5 clk = ~clk;

  pe_psum_collector_if #(.DATA_W(DATA_W), .ACC_W(ACC_W),   .FIFO_DEPTH(DEPTH)) io();
  pe_psum_collector_if #(.DATA_W(DATA_W), .ACC_W(ACC_W_N), .FIFO_DEPTH(DEPTH)) io_n();

  assign io.en         = en;
  assign io.num_rows   = num_rows;
  assign io.opsum_seln = opsum_seln;
  assign io.opsum_in   = opsum_in;
  assign io.out_ready  = out_ready;
  assign io_n.en         = en;
  assign io_n.num_rows   = num_rows;
  assign io_n.opsum_seln = opsum_seln;
  assign io_n.opsum_in   = opsum_in;
  assign io_n.out_ready  = out_ready;

  pe_psum_collector #(.DATA_W(DATA_W), .ACC_W(ACC_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io)
  );

  pe_psum_collector #(.DATA_W(DATA_W), .ACC_W(ACC_W_N), .FIFO_DEPTH(DEPTH)) dut_n (
    .clk (clk),
    .rst (rst),
    .io  (io_n)
  );

  typedef struct packed {
    logic [7:0]                   rows;
    logic [7:0][DATA_W-1:0]       v;
    logic [ACC_W-1:0]             exp_sum;
  } vec_t;

  vec_t vecs [NV];
  int   fv [5];

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One valid opsum, sampled on the next rising edge.
  task automatic send(input logic [DATA_W-1:0] v);
    opsum_seln = 1'b0;
    opsum_in   = v;
    tick();
    opsum_seln = 1'b1;
  endtask

  task automatic wait_drain(input string name);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || io.fifo_count != 0) && k < DRAIN_BOUND) begin
      tick();
      k++;
    end
    checks++;
    if (k >= DRAIN_BOUND) begin
      failures++;
      $display("FAIL %s timeout pending=%0d fifo_count=%0d required=0", name,
               exp_q.size(), io.fifo_count);
      exp_q.delete();
    end
  endtask

  task automatic set_vec(input int i, input int r,
                         input int a0, input int a1, input int a2, input int a3,
                         input int a4, input int a5, input int a6, input int a7,
                         input int e);
    vecs[i].rows    = 8'(r);
    vecs[i].v[0]    = DATA_W'(a0);
    vecs[i].v[1]    = DATA_W'(a1);
    vecs[i].v[2]    = DATA_W'(a2);
    vecs[i].v[3]    = DATA_W'(a3);
    vecs[i].v[4]    = DATA_W'(a4);
    vecs[i].v[5]    = DATA_W'(a5);
    vecs[i].v[6]    = DATA_W'(a6);
    vecs[i].v[7]    = DATA_W'(a7);
    vecs[i].exp_sum = ACC_W'(e);
  endtask

  // Scoreboard: every accepted head is compared with the oldest expectation.
  always @(negedge clk) begin
    if (!rst && io.out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected actual=%0d required=no_output", $signed(io.out_data));
      end else begin
        check("sb_data", $signed(io.out_data), exp_q.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    longint exp_main;
    longint exp_n;
    logic [DATA_W-1:0] big;

    set_vec(0, 3,     5,    -2,    7,     0,   0,  0,  0,   0,    10);
    set_vec(1, 1,   100,     0,    0,     0,   0,  0,  0,   0,   100);
    set_vec(2, 2, -32768, -32768,  0,     0,   0,  0,  0,   0, -65536);
    set_vec(3, 4, 32767, 32767, 32767, 32767,  0,  0,  0,   0, 131068);
    set_vec(4, 5,     1,    -1,    2,    -2,   3,  0,  0,   0,     3);
    set_vec(5, 8,     1,     2,    4,     8,  16, 32, 64, 128,   255);
    set_vec(6, 2,    -1,     0,    0,     0,   0,  0,  0,   0,    -1);
    set_vec(7, 6,  -300,  -200, -100,    50,  25, -5,  0,   0,  -530);
    fv = '{11, -22, 33, -44, 55};

    // Reset state
    repeat (3) tick();
    check("rst_out_valid",  io.out_valid, 0);
    check("rst_out_data",   io.out_data, 0);
    check("rst_fifo_count", io.fifo_count, 0);
    check("rst_drop_err",   io.drop_err, 0);
    rst = 1'b0;

    // 5,-2,7 in a group of 3: total visible for exactly one cycle, two cycles
    // after the cycle carrying the last opsum.
    en = 1'b1; num_rows = 8'd3; out_ready = 1'b1;
    tick();
    exp_q.push_back(ACC_W'(10));
    send(DATA_W'(5));
    send(DATA_W'(-2));
    en = 1'b0;
    send(DATA_W'(7));
    check("lat_push_cycle_valid", io.out_valid, 0);
    tick();
    check("lat_valid", io.out_valid, 1);
    check("lat_data", $signed(io.out_data), 10);
    tick();
    check("lat_one_cycle", io.out_valid, 0);

    // num_rows=0 behaves as groups of one.
    num_rows = 8'd0; en = 1'b1;
    tick();
    exp_q.push_back(ACC_W'(4));
    exp_q.push_back(ACC_W'(9));
    send(DATA_W'(4));
    tick();
    en = 1'b0;
    send(DATA_W'(9));
    wait_drain("rows0_drain");

    // Table: each group starts from IDLE (with an opsum that must be ignored
    // there), drops en after the first opsum, and has idle gaps.
    for (int t = 0; t < NV; t++) begin
      en = 1'b0; opsum_seln = 1'b0; opsum_in = 16'h1234;
      tick();
      opsum_seln = 1'b1;
      num_rows = vecs[t].rows; en = 1'b1;
      tick();
      exp_q.push_back(vecs[t].exp_sum);
      for (int i = 0; i < int'(vecs[t].rows); i++) begin
        send(vecs[t].v[i]);
        en = 1'b0;
        if ((i % 2 == 1) && (i < int'(vecs[t].rows) - 1)) begin
          opsum_in = 16'h7fff;
          tick();
        end
      end
      wait_drain($sformatf("vec%0d_drain", t));
    end
    check("vec_drop_err", io.drop_err, 0);

    // 255 rows of the extreme values: fits in 24 bits, overflows 18 bits.
    for (int s = 0; s < 2; s++) begin
      if (s == 0) begin
        big = 16'h7fff; exp_main = 8355585;
`ifdef PE_PSUM_SATURATE_EN
        exp_n = 131071;
`else
        exp_n = -33023;
`endif
      end else begin
        big = 16'h8000; exp_main = -8355840;
`ifdef PE_PSUM_SATURATE_EN
        exp_n = -131072;
`else
        exp_n = 32768;
`endif
      end
      num_rows = 8'd255; en = 1'b1;
      tick();
      exp_q.push_back(ACC_W'(exp_main));
      for (int i = 0; i < 255; i++) begin
        send(big);
        en = 1'b0;
      end
      tick();
      check($sformatf("narrow%0d_valid", s), io_n.out_valid, 1);
      check($sformatf("narrow%0d_data", s), $signed(io_n.out_data), exp_n);
      wait_drain($sformatf("wide%0d_drain", s));
    end

    // Full FIFO: four groups stored, fifth held in PUSH, extra opsum dropped.
    out_ready = 1'b0; num_rows = 8'd1; en = 1'b1;
    tick();
    for (int k = 0; k < 5; k++) begin
      exp_q.push_back(ACC_W'(fv[k]));
      send(DATA_W'(fv[k]));
      if (k < 4) tick();
    end
    check("full_count", io.fifo_count, 4);
    check("full_no_drop_yet", io.drop_err, 0);
    send(DATA_W'(99));
    check("full_drop_err", io.drop_err, 1);
    check("full_held_count", io.fifo_count, 4);
    check("full_head_stable", $signed(io.out_data), fv[0]);
    en = 1'b0; out_ready = 1'b1;
    tick();
    check("pushpop_count", io.fifo_count, 4);
    check("pushpop_drop_sticky", io.drop_err, 1);
    wait_drain("full_drain");

    // Reset mid-group with a stored entry: everything is cleared.
    out_ready = 1'b0; num_rows = 8'd3; en = 1'b1;
    tick();
    send(DATA_W'(1));
    send(DATA_W'(2));
    send(DATA_W'(3));
    tick();
    check("pre_rst_count", io.fifo_count, 1);
    send(DATA_W'(11));
    send(DATA_W'(22));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_drop_err",   io.drop_err, 0);
    check("mid_rst_fifo_count", io.fifo_count, 0);
    check("mid_rst_out_valid",  io.out_valid, 0);
    check("mid_rst_out_data",   io.out_data, 0);
    num_rows = 8'd3; en = 1'b1; out_ready = 1'b1;
    tick();
    exp_q.push_back(ACC_W'(18));
    send(DATA_W'(5));
    send(DATA_W'(6));
    en = 1'b0;
    send(DATA_W'(7));
    wait_drain("post_rst_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
